// File: rtl/or_reduce_pipe_pkg.sv
// Shared helpers for or_reduce_pipe: tree-depth / stage-count functions and the
// bit layout of the sideband word that travels with each beat through the tree.
package or_reduce_pipe_pkg;

   // Ceiling log2; returns 0 for values <= 1.
   function automatic int orn_clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

   function automatic int orn_depth(input int width);
      return orn_clog2(width);
   endfunction

   function automatic int orn_stages(input int width, input int levels_per_stage);
      return (orn_depth(width) + levels_per_stage - 1) / levels_per_stage;
   endfunction

   function automatic int orn_idxw(input int width);
      return (orn_clog2(width) < 1) ? 1 : orn_clog2(width);
   endfunction

   // Sideband bit positions; hit/index fields exist only with the first-index option.
   localparam int SB_VALID  = 0;
   localparam int SB_ACC    = 1;
   localparam int SB_LAST   = 2;
   localparam int SB_HIT    = 3;
   localparam int SB_IDX    = 4;
   localparam int SB_BASE_W = 3;

endpackage

// File: rtl/or_reduce_pipe_tree_stage.sv
// or_tree_stage: one registered slice of LEVELS OR-tree levels over N_IN inputs,
// with a stall enable; sideband bits ride along unchanged.
module or_tree_stage
   import or_reduce_pipe_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int LEVELS = 1,
   parameter int SB_W   = SB_BASE_W
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        en_i,
   input  logic [N_IN-1:0]             data_i,
   input  logic [SB_W-1:0]             sb_i,
   output logic [(N_IN >> LEVELS)-1:0] data_o,
   output logic [SB_W-1:0]             sb_o
);

   localparam int GRP   = 1 << LEVELS;
   localparam int N_OUT = N_IN >> LEVELS;

   logic [N_OUT-1:0] data_d;
   logic [N_OUT-1:0] data_q;
   logic [SB_W-1:0]  sb_q;

   // Each output is the OR of an aligned group of 2**LEVELS neighbours, i.e. LEVELS tree levels.
   always_comb begin
      data_d = '0;
      for (int j = 0; j < N_OUT; j++) begin
         data_d[j] = |data_i[j*GRP +: GRP];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         data_q <= '0;
         sb_q   <= '0;
      end else if (en_i) begin
         data_q <= data_d;
         sb_q   <= sb_i;
      end
   end

   assign data_o = data_q;
   assign sb_o   = sb_q;

endmodule

// File: rtl/or_reduce_pipe.sv
// Pipelined WIDTH-input OR reducer with valid/ready backpressure and multi-beat accumulate.
// Optional macro ORN_FIRST_IDX_EN adds out_idx, the lowest set bit index of the beat/packet.
module or_reduce_pipe
   import or_reduce_pipe_pkg::*;
#(
   parameter int WIDTH            = 8,
   parameter int LEVELS_PER_STAGE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_acc,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out,
   output logic             out_valid,
   input  logic             out_ready
`ifdef ORN_FIRST_IDX_EN
   ,
   output logic [orn_idxw(WIDTH)-1:0] out_idx
`endif
);

   localparam int D    = orn_depth(WIDTH);
   localparam int S    = orn_stages(WIDTH, LEVELS_PER_STAGE);
   localparam int P    = 1 << D;
   localparam int IDXW = orn_idxw(WIDTH);
`ifdef ORN_FIRST_IDX_EN
   localparam int SB_W = SB_IDX + IDXW;
`else
   localparam int SB_W = SB_BASE_W;
`endif

   logic            adv_s;
   logic [P-1:0]    pad_s;
   logic [SB_W-1:0] sb0_s;
   logic            tree_r_s;
   logic [SB_W-1:0] tree_sb_s;
   logic            beat_v_s;
   logic            beat_acc_s;
   logic            beat_last_s;

   logic out_d;
   logic out_q;
   logic out_valid_d;
   logic out_valid_q;
   logic acc_d;
   logic acc_q;

`ifdef ORN_FIRST_IDX_EN
   logic            hit_s;
   logic [IDXW-1:0] idx_s;
   logic            beat_hit_s;
   logic [IDXW-1:0] beat_idx_s;
   logic [IDXW-1:0] idx_d;
   logic [IDXW-1:0] idx_q;
   logic            idx_seen_d;
   logic            idx_seen_q;
   logic [IDXW-1:0] out_idx_d;
   logic [IDXW-1:0] out_idx_q;
`endif

   // One global stall: nothing moves while a result is waiting to be taken.
   assign adv_s    = !out_valid_q || out_ready;
   assign in_ready = adv_s;

   always_comb begin
      pad_s              = '0;
      pad_s[WIDTH-1:0]   = in_data;
   end

`ifdef ORN_FIRST_IDX_EN
   // Scanning from the top down leaves the lowest set bit's index in idx_s.
   always_comb begin
      hit_s = |in_data;
      idx_s = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         idx_s = in_data[i] ? IDXW'(i) : idx_s;
      end
   end
`endif

   // acc/last are masked with valid so idle cycles carry no stray packet markers.
   always_comb begin
      sb0_s          = '0;
      sb0_s[SB_VALID] = in_valid;
      sb0_s[SB_ACC]   = in_valid & in_acc;
      sb0_s[SB_LAST]  = in_valid & in_acc & in_last;
`ifdef ORN_FIRST_IDX_EN
      sb0_s[SB_HIT]           = hit_s;
      sb0_s[SB_IDX +: IDXW]   = idx_s;
`endif
   end

   for (genvar k = 0; k < S; k++) begin : g_stage
      localparam int REM  = D - k * LEVELS_PER_STAGE;
      localparam int LV   = (REM < LEVELS_PER_STAGE) ? REM : LEVELS_PER_STAGE;
      localparam int N_IN = 1 << REM;

      logic [N_IN-1:0]         din_s;
      logic [(N_IN >> LV)-1:0] dout_s;
      logic [SB_W-1:0]         sbin_s;
      logic [SB_W-1:0]         sbout_s;

      if (k == 0) begin : g_head
         assign din_s  = pad_s;
         assign sbin_s = sb0_s;
      end else begin : g_link
         assign din_s  = g_stage[k-1].dout_s;
         assign sbin_s = g_stage[k-1].sbout_s;
      end

      or_tree_stage #(
         .N_IN   (N_IN),
         .LEVELS (LV),
         .SB_W   (SB_W)
      ) u_stage (
         .clk_i   (clk),
         .reset_i (reset),
         .en_i    (adv_s),
         .data_i  (din_s),
         .sb_i    (sbin_s),
         .data_o  (dout_s),
         .sb_o    (sbout_s)
      );
   end

   assign tree_r_s    = g_stage[S-1].dout_s[0];
   assign tree_sb_s   = g_stage[S-1].sbout_s;
   assign beat_v_s    = tree_sb_s[SB_VALID];
   assign beat_acc_s  = tree_sb_s[SB_ACC];
   assign beat_last_s = tree_sb_s[SB_LAST];
`ifdef ORN_FIRST_IDX_EN
   assign beat_hit_s  = tree_sb_s[SB_HIT];
   assign beat_idx_s  = tree_sb_s[SB_IDX +: IDXW];
`endif

   // Output/accumulate stage; a plain beat inside an open packet leaves acc_q/idx_q alone.
   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      acc_d       = acc_q;
`ifdef ORN_FIRST_IDX_EN
      idx_d       = idx_q;
      idx_seen_d  = idx_seen_q;
      out_idx_d   = out_idx_q;
`endif
      if (adv_s) begin
         if (beat_v_s) begin
            if (!beat_acc_s) begin
               out_d       = tree_r_s;
               out_valid_d = 1'b1;
`ifdef ORN_FIRST_IDX_EN
               out_idx_d   = beat_idx_s;
`endif
            end else if (!beat_last_s) begin
               acc_d       = acc_q | tree_r_s;
               out_valid_d = 1'b0;
`ifdef ORN_FIRST_IDX_EN
               idx_d       = (!idx_seen_q && beat_hit_s) ? beat_idx_s : idx_q;
               idx_seen_d  = idx_seen_q | beat_hit_s;
`endif
            end else begin
               out_d       = acc_q | tree_r_s;
               out_valid_d = 1'b1;
               acc_d       = 1'b0;
`ifdef ORN_FIRST_IDX_EN
               out_idx_d   = idx_seen_q ? idx_q : beat_idx_s;
               idx_d       = '0;
               idx_seen_d  = 1'b0;
`endif
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q       <= 1'b0;
         out_valid_q <= 1'b0;
         acc_q       <= 1'b0;
`ifdef ORN_FIRST_IDX_EN
         idx_q       <= '0;
         idx_seen_q  <= 1'b0;
         out_idx_q   <= '0;
`endif
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         acc_q       <= acc_d;
`ifdef ORN_FIRST_IDX_EN
         idx_q       <= idx_d;
         idx_seen_q  <= idx_seen_d;
         out_idx_q   <= out_idx_d;
`endif
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
`ifdef ORN_FIRST_IDX_EN
   assign out_idx   = out_idx_q;
`endif

endmodule
